// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D main-memory arbiter.
// The optional starvation guard is enabled with MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int DEF_TIMEOUT     = 64;
  localparam int DEF_MAX_DSTREAK = 4;
  localparam int TMO_W           = 8;

  // Width of the D-streak counter; at least one bit so the port never collapses.
  function automatic int streak_w(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the arbiter: D priority, optionally yielding to I after a D streak.
// Streak-based yielding is compiled in only with MEM_ARB_STARVE_GUARD_EN.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK,
  parameter int SW          = streak_w(MAX_DSTREAK)
) (
  input  logic          d_req,
  input  logic          i_req,
  input  logic [SW-1:0] dstreak,
  output logic          grant_d,
  output logic          grant_i
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic i_turn;

  assign i_turn  = i_req && (dstreak == SW'(MAX_DSTREAK));
  assign grant_d = d_req && !i_turn;
  assign grant_i = i_req && (!d_req || i_turn);
`else
  logic unused_dstreak;

  assign unused_dstreak = ^dstreak;
  assign grant_d = d_req;
  assign grant_i = i_req && !d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache fills and D-cache fills/writebacks,
// one transaction at a time, with a timeout watchdog. Macro: MEM_ARB_STARVE_GUARD_EN.
//
// state   | meaning
// IDLE    | no transaction; sample requests and grant one
// ISSUE   | m_req held with latched command until m_ack
// WAIT_RD | read accepted, waiting for m_rvalid
// RESP    | one-cycle done pulse to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          err
);

  localparam int SW = streak_w(MAX_DSTREAK);
  // Abort on the edge where the count would reach TIMEOUT-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [TMO_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             err_q, err_d;
  logic [SW-1:0]    dstreak;
  logic             gnt_d, gnt_i;
  logic             wd_hit;

  mem_arb_pick #(
    .MAX_DSTREAK (MAX_DSTREAK),
    .SW          (SW)
  ) u_pick (
    .d_req   (d_req),
    .i_req   (i_req),
    .dstreak (dstreak),
    .grant_d (gnt_d),
    .grant_i (gnt_i)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [SW-1:0] dstreak_q, dstreak_d;

  always_comb begin
    dstreak_d = dstreak_q;
    if (state_q == IDLE) begin
      if (gnt_i || !i_req) begin
        dstreak_d = '0;
      end else if (gnt_d) begin
        dstreak_d = dstreak_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dstreak_q <= '0;
    end else begin
      dstreak_q <= dstreak_d;
    end
  end

  assign dstreak = dstreak_q;
`else
  assign dstreak = '0;
`endif

  assign wd_hit = (wd_cnt_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (gnt_d) begin
          owner_d = OWN_D;
          wr_d    = d_wr;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (gnt_i) begin
          owner_d = OWN_I;
          wr_d    = 1'b0;
          addr_d  = i_addr;
          wdata_d = '0;
        end
        if (gnt_d || gnt_i) begin
          rdata_d  = '0;
          wd_cnt_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wd_cnt_d = wd_cnt_q + TMO_W'(1);
        if (m_ack) begin
          state_d = wr_q ? RESP : WAIT_RD;
        end
        // An accepted write completes this cycle; anything else still pending aborts.
        if (wd_hit && !(m_ack && wr_q)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      WAIT_RD: begin
        wd_cnt_d = wd_cnt_q + TMO_W'(1);
        if (m_rvalid) begin
          rdata_d = m_rdata;
          state_d = RESP;
        end else if (wd_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign m_req   = (state_q == ISSUE);
  assign m_wr    = (state_q == ISSUE) && wr_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_done  = (state_q == RESP) && (owner_q == OWN_I);
  assign d_done  = (state_q == RESP) && (owner_q == OWN_D);
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle expectation trace is built from
// transaction timing rules and compared against the DUT on every falling edge.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int TMO  = 8;
  localparam int MAXS = 4;
  localparam int NCYC = 512;
  localparam int NEVER = 1 << 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          busy;
  logic          err;

  mem_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT     (TMO),
    .MAX_DSTREAK (MAXS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_done   (i_done),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected trace and memory-side stimulus, indexed by absolute cycle.
  bit        e_busy [NCYC];
  bit        e_mreq [NCYC];
  bit        e_wr   [NCYC];
  bit        e_idone[NCYC];
  bit        e_ddone[NCYC];
  bit        e_err  [NCYC];
  bit [15:0] e_addr [NCYC];
  bit [15:0] e_wdata[NCYC];
  bit [15:0] e_rdata[NCYC];
  bit        drv_ack[NCYC];
  bit        drv_rv [NCYC];
  bit [15:0] drv_rdata[NCYC];

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // Transaction timing: request seen at cycle s, command on the bus from s+1
  // until accepted, completion (write ack / read data) at cycle c gives done at
  // c+1; no completion by relative cycle TMO-1 gives an error done at s+TMO.
  task automatic plan(input int s, input bit own_d, input bit wr,
                      input bit [15:0] addr, input bit [15:0] wdata,
                      input int ack_at, input int rv_at, input bit [15:0] rdata,
                      input int abort_at, output int resp_abs);
    int comp;
    int resp;
    bit tmo;
    if (ack_at < 0)          comp = NEVER;
    else if (wr)             comp = ack_at;
    else if (rv_at > ack_at) comp = rv_at;
    else                     comp = NEVER;
    tmo  = (comp > TMO - 1);
    resp = tmo ? TMO : comp + 1;
    for (int t = 1; t <= resp && t < abort_at; t++) begin
      e_busy[s+t] = 1'b1;
      if (t < resp && (ack_at < 0 || t <= ack_at)) begin
        e_mreq[s+t]  = 1'b1;
        e_wr[s+t]    = wr;
        e_addr[s+t]  = addr;
        e_wdata[s+t] = wdata;
      end
      if (t == resp) begin
        if (own_d) e_ddone[s+t] = 1'b1;
        else       e_idone[s+t] = 1'b1;
        e_rdata[s+t] = (tmo || wr) ? 16'h0000 : rdata;
        if (tmo) for (int k = s + t; k < NCYC; k++) e_err[k] = 1'b1;
      end
    end
    if (ack_at >= 0 && ack_at < resp) drv_ack[s+ack_at] = 1'b1;
    if (!wr && rv_at >= 0) begin
      drv_rv[s+rv_at]    = 1'b1;
      drv_rdata[s+rv_at] = rdata;
    end
    resp_abs = s + resp;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      cmp("busy",   16'(busy),   16'(e_busy[cyc]));
      cmp("m_req",  16'(m_req),  16'(e_mreq[cyc]));
      cmp("i_done", 16'(i_done), 16'(e_idone[cyc]));
      cmp("d_done", 16'(d_done), 16'(e_ddone[cyc]));
      cmp("err",    16'(err),    16'(e_err[cyc]));
      if (e_mreq[cyc]) begin
        cmp("m_addr", m_addr, e_addr[cyc]);
        cmp("m_wr", 16'(m_wr), 16'(e_wr[cyc]));
        if (e_wr[cyc]) cmp("m_wdata", m_wdata, e_wdata[cyc]);
      end
      if (e_idone[cyc]) cmp("i_rdata", i_rdata, e_rdata[cyc]);
      if (e_ddone[cyc]) cmp("d_rdata", d_rdata, e_rdata[cyc]);
    end
  end

  initial begin
    m_ack    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc < NCYC) begin
        m_ack    = drv_ack[cyc];
        m_rvalid = drv_rv[cyc];
        m_rdata  = drv_rdata[cyc];
      end else begin
        m_ack    = 1'b0;
        m_rvalid = 1'b0;
      end
    end
  end

  initial begin
    int s;
    int r;
    int r1;
    int streak;
    rst     = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;

    wait_until(1);
    cmp("rst_m_addr",  m_addr,  16'h0000);
    cmp("rst_m_wdata", m_wdata, 16'h0000);
    cmp("rst_m_wr",    16'(m_wr), 16'h0000);
    cmp("rst_i_rdata", i_rdata, 16'h0000);
    cmp("rst_d_rdata", d_rdata, 16'h0000);
    wait_until(2);
    rst = 1'b1;

    // I-side read, data returned two cycles after accept
    s = 4;
    wait_until(s);
    i_req = 1'b1; i_addr = 16'h0040;
    plan(s, 1'b0, 1'b0, 16'h0040, 16'h0000, 1, 3, 16'hBEEF, NEVER, r);
    cmp_int("i_read_done_cycle", r - s, 4);
    wait_until(s + 1);
    cmp("i_read_m_addr", m_addr, 16'h0040);
    wait_until(r);
    i_req = 1'b0;
    cmp("i_read_done", 16'(i_done), 16'h0001);
    cmp("i_read_data", i_rdata, 16'hBEEF);

    // D-side write, immediate accept
    s = r + 2;
    wait_until(s);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1000; d_wdata = 16'h1234;
    plan(s, 1'b1, 1'b1, 16'h1000, 16'h1234, 1, -1, 16'h0000, NEVER, r);
    cmp_int("d_write_done_cycle", r - s, 2);
    wait_until(s + 1);
    cmp("d_write_m_wdata", m_wdata, 16'h1234);
    cmp("d_write_m_wr", 16'(m_wr), 16'h0001);
    wait_until(r);
    d_req = 1'b0;
    cmp("d_write_done", 16'(d_done), 16'h0001);
    cmp("d_write_rdata", d_rdata, 16'h0000);

    // Accept withheld five cycles; request inputs scrambled after the grant
    s = r + 2;
    wait_until(s);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1888; d_wdata = 16'h0F0F;
    plan(s, 1'b1, 1'b1, 16'h1888, 16'h0F0F, 6, -1, 16'h0000, NEVER, r);
    wait_until(s + 1);
    d_addr = 16'hFFFF; d_wdata = 16'h0000; d_wr = 1'b0;
    wait_until(s + 5);
    cmp("stall_m_addr", m_addr, 16'h1888);
    wait_until(r);
    d_req = 1'b0;

    // Memory never accepts: watchdog aborts with error
    s = r + 2;
    wait_until(s);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4444;
    plan(s, 1'b1, 1'b0, 16'h4444, 16'h0000, -1, -1, 16'h0000, NEVER, r);
    wait_until(s + 7);
    cmp("tmo_err_before", 16'(err), 16'h0000);
    wait_until(r);
    d_req = 1'b0;
    cmp_int("tmo_done_cycle", r - s, 8);
    cmp("tmo_err", 16'(err), 16'h0001);
    cmp("tmo_d_done", 16'(d_done), 16'h0001);
    cmp("tmo_d_rdata", d_rdata, 16'h0000);

    // Simultaneous requests: D first, I granted in the following IDLE
    s = r + 2;
    wait_until(s);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h2000; d_wdata = 16'h5555;
    i_req = 1'b1; i_addr = 16'h0080;
    plan(s, 1'b1, 1'b1, 16'h2000, 16'h5555, 1, -1, 16'h0000, NEVER, r1);
    plan(r1 + 1, 1'b0, 1'b0, 16'h0080, 16'h0000, 1, 2, 16'hCAFE, NEVER, r);
    wait_until(s + 1);
    cmp("simul_first_addr", m_addr, 16'h2000);
    wait_until(r1);
    d_req = 1'b0;
    wait_until(r1 + 2);
    cmp("simul_second_addr", m_addr, 16'h0080);
    wait_until(r);
    i_req = 1'b0;
    cmp("simul_err_sticky", 16'(err), 16'h0001);

    // Reset while waiting for read data; late data must be ignored
    s = r + 2;
    wait_until(s);
    i_req = 1'b1; i_addr = 16'h0C00;
    plan(s, 1'b0, 1'b0, 16'h0C00, 16'h0000, 1, 4, 16'hDEAD, 3, r);
    wait_until(s + 2);
    rst = 1'b0; i_req = 1'b0;
    for (int k = s + 3; k < NCYC; k++) e_err[k] = 1'b0;
    wait_until(s + 3);
    rst = 1'b1;
    cmp("rst_mid_busy", 16'(busy), 16'h0000);
    cmp("rst_mid_err", 16'(err), 16'h0000);

    // D read after reset, slow accept and slow data
    s = s + 6;
    wait_until(s);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0A0A;
    plan(s, 1'b1, 1'b0, 16'h0A0A, 16'h0000, 2, 4, 16'h7777, NEVER, r);
    wait_until(r);
    d_req = 1'b0;
    cmp("d_read_data", d_rdata, 16'h7777);

    // Continuous D and I requests
    s = r + 2;
    streak = 0;
    wait_until(s);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h3000; d_wdata = 16'h00AA;
    i_req = 1'b1; i_addr = 16'h0100;
    for (int k = 0; k < 10; k++) begin
      bit pick_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
      pick_i = (streak == MAXS);
`else
      pick_i = 1'b0;
`endif
      if (pick_i) begin
        plan(s, 1'b0, 1'b0, 16'h0100, 16'h0000, 1, 2, 16'(16'h1100 + k), NEVER, r);
        streak = 0;
      end else begin
        plan(s, 1'b1, 1'b1, 16'h3000, 16'h00AA, 1, -1, 16'h0000, NEVER, r);
        streak++;
      end
      if (k == 4) begin
        wait_until(s + 1);
`ifdef MEM_ARB_STARVE_GUARD_EN
        cmp("grant5_addr", m_addr, 16'h0100);
`else
        cmp("grant5_addr", m_addr, 16'h3000);
`endif
      end
      s = r + 1;
    end
    wait_until(r);
    d_req = 1'b0;
    plan(s, 1'b0, 1'b0, 16'h0100, 16'h0000, 1, 2, 16'h2222, NEVER, r);
    wait_until(r);
    i_req = 1'b0;
    cmp("starve_tail_i_data", i_rdata, 16'h2222);

    wait_until(r + 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
